// File: rtl/ps2_rx_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head with valid/ready plus error pulses.
interface ps2_rx_if;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  modport master (output data_out, valid, parity_err, frame_err, overflow, input ready);
  modport slave  (input data_out, valid, parity_err, frame_err, overflow, output ready);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin sync + clock de-glitch, 11-bit deframer with
// odd parity / stop check and mid-frame timeout, first-word fall-through byte FIFO.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master bus
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic                 clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic                 filt_q, filt_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic                 strobe;
  logic [1:0]           state_q, state_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic                 push_q, push_d;
  logic [7:0]           pbyte_q, pbyte_d;
  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 pop, full, push_ok;

  // Clock filter: the filtered level flips only after FILTER_LEN straight disagreeing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    strobe = filt_q & ~filt_d;
  end

  // Deframer: advances on strobes only; the timeout aborts any partial frame
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    push_d  = 1'b0;
    pbyte_d = pbyte_q;
    if (state_q == S_IDLE || strobe) tmo_d = '0;
    else                             tmo_d = tmo_q + 1'b1;
    case (state_q)
      S_IDLE: if (strobe && !dat_s2_q) begin
        state_d = S_DATA;
        bcnt_d  = 3'd0;
      end
      S_DATA: if (strobe) begin
        shift_d = {dat_s2_q, shift_q[7:1]};
        bcnt_d  = bcnt_q + 1'b1;
        if (bcnt_q == 3'd7) state_d = S_PAR;
      end
      S_PAR: if (strobe) begin
        par_d   = dat_s2_q;
        state_d = S_STOP;
      end
      default: if (strobe) begin
        state_d = S_IDLE;
        // Parity only matters once the stop bit proves the frame was framed correctly
        if (!dat_s2_q)                  ferr_d = 1'b1;
        else if (^{shift_q, par_q} == 1'b0) perr_d = 1'b1;
        else begin
          push_d  = 1'b1;
          pbyte_d = shift_q;
        end
      end
    endcase
    if (state_q != S_IDLE && !strobe && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // FIFO: a full FIFO still accepts a push when the head is popped the same cycle
  always_comb begin
    pop     = (count_q != '0) && bus.ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    push_ok = push_q && (!full || pop);
    ovf_d   = push_q && full && !pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = pbyte_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  assign bus.valid      = (count_q != '0);
  assign bus.data_out   = bus.valid ? mem_q[rd_q] : 8'h00;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;

  // State registers; synchronisers idle high like the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      push_q   <= 1'b0;
      pbyte_q  <= '0;
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      push_q   <= push_d;
      pbyte_q  <= pbyte_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// Randomised scoreboard bench for ps2_rx: frames are built from the PS/2 framing rules,
// a queue-based FIFO model predicts delivered bytes, overflow and error pulse counts.
module tb_ps2_rx;
  localparam int DEPTH = 4;
  localparam int H     = 20;   // half bit period in clk cycles
  localparam int TMO   = 50000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_if bus();

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int got_perr = 0, got_ferr = 0, got_ovf = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Random ready generator, only when enabled
  always @(negedge clk) if (rnd_rdy) bus.ready = 1'($urandom_range(0, 1));

  // Monitor: samples between edges, pops the scoreboard on every handshake, counts pulses
  initial begin
    bit pp, pf, po;
    int n;
    pp = 0; pf = 0; po = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pp = 0; pf = 0; po = 0;
      end else begin
        if (bus.valid && bus.ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop: got 0x%0h expected no data", bus.data_out);
          end else chk("pop_data", int'(bus.data_out), int'(sb.pop_front()));
        end
        n = int'(bus.parity_err) + int'(bus.frame_err) + int'(bus.overflow);
        if (n > 0) begin
          chk("pulse_exclusive", n, 1);
          chk("pulse_width", int'((bus.parity_err && pp) || (bus.frame_err && pf) || (bus.overflow && po)), 0);
        end
        if (bus.parity_err) got_perr++;
        if (bus.frame_err)  got_ferr++;
        if (bus.overflow)   got_ovf++;
        pp = bus.parity_err; pf = bus.frame_err; po = bus.overflow;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit d, input bit glitch);
    ps2_data = d;
    cyc(H / 2);
    ps2_clk = 1'b0;
    cyc(H);
    ps2_clk = 1'b1;
    if (glitch) begin
      cyc(2); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(H / 2 - 5);
    end else cyc(H / 2);
  endtask

  task automatic chk_counts();
    chk("parity_err_count", got_perr, exp_perr);
    chk("frame_err_count", got_ferr, exp_ferr);
    chk("overflow_count", got_ovf, exp_ovf);
  endtask

  // One frame; ready is held low across the stop bit so the model decision sees the
  // FIFO as the DUT does, optionally with a single pop exactly on the push cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input bit pulse_pop);
    bit par, saved_rnd, saved_rdy, pulsed;
    par = (~^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    saved_rnd = rnd_rdy; saved_rdy = bus.ready;
    rnd_rdy = 1'b0;
    @(negedge clk);
    bus.ready = 1'b0;
    ps2_data = ~bad_stop;
    cyc(H / 2);
    ps2_clk = 1'b0;
    pulsed = 1'b0;
    repeat (H) begin
      @(negedge clk);
      if (pulse_pop && !pulsed && dut.push_q) begin
        bus.ready = 1'b1; pulsed = 1'b1;
      end else bus.ready = 1'b0;
    end
    ps2_clk = 1'b1;
    cyc(H / 2);
    if (pulse_pop) chk("pop_on_push_seen", int'(pulsed), 1);
    if (bad_stop)               exp_ferr++;
    else if (bad_par)           exp_perr++;
    else if (sb.size() == DEPTH) exp_ovf++;
    else                        sb.push_back(b);
    ps2_data = 1'b1;
    chk_counts();
    bus.ready = saved_rdy; rnd_rdy = saved_rnd;
    cyc(H);
  endtask

  task automatic drain_check(input string name);
    rnd_rdy = 1'b0;
    bus.ready = 1'b1;
    cyc(DEPTH + 4);
    #2;
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_valid_low"}, int'(bus.valid), 0);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    bus.ready = 1'b0;
    cyc(4);
    rst = 1'b0;
    @(negedge clk); #2;
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_data_out", int'(bus.data_out), 0);
    chk("reset_parity_err", int'(bus.parity_err), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    cyc(H);

    // Clean frame with a permanent consumer
    bus.ready = 1'b1;
    send_frame(8'h1C, 0, 0, 0, 0);
    drain_check("t1");

    // Bad parity, then bad stop bit
    send_frame(8'h1C, 1, 0, 0, 0);
    send_frame(8'hF0, 0, 1, 0, 0);
    drain_check("t2");

    // Timeout mid-frame, then a good frame
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    cyc(TMO + 50);
    exp_ferr++;
    chk_counts();
    send_frame(8'hF0, 0, 0, 0, 0);
    drain_check("t3");

    // Fill, overflow, drain in order
    bus.ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 0, 0, 0, 0);
    drain_check("t4a");
    // Full FIFO with a pop on the push cycle: no overflow, occupancy unchanged
    bus.ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i * 8'h11), 0, 0, 0, 0);
    send_frame(8'h66, 0, 0, 0, 1);
    #2;
    chk("t4b_full_after_pushpop", int'(bus.valid), 1);
    chk("t4b_model_occupancy", sb.size(), DEPTH);
    drain_check("t4b");

    // Glitches between bits must not produce extra strobes
    send_frame(8'h5A, 0, 0, 1, 0);
    drain_check("t5");

    // Reset after the 5th data bit; trailing bits of 0xF0 are all ones
    b = 8'hF0;
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(b[i], 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    sb.delete();
    for (int i = 5; i < 8; i++) send_bit(b[i], 0);
    send_bit(~^b, 0);
    send_bit(1'b1, 0);
    #2;
    chk("t6_valid_after_reset", int'(bus.valid), 0);
    chk_counts();
    send_frame(8'h29, 0, 0, 0, 0);
    drain_check("t6");

    // Randomised frames, error kinds and consumer behaviour
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: begin rnd_rdy = 1'b0; @(negedge clk); bus.ready = 1'b0; end
        1: begin rnd_rdy = 1'b0; @(negedge clk); bus.ready = 1'b1; end
        default: rnd_rdy = 1'b1;
      endcase
      b = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      send_frame(b, kind == 8, kind == 9, 1'($urandom_range(0, 1)), 0);
    end
    drain_check("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
